pc_fetch_ctrl: RTL and testbench

Fetch-stage PC controller: the consumer end of the branch-resolution interface. It owns the fetch PC register, drives the synchronous instruction-memory address, and tags each returned instruction with its PC and a valid bit. It accepts redirects (`PcSel`/`BrPC`) from the EX-stage branch unit, asserts the IF/ID and ID/EX flushes, and inserts the squash bubble. It sits between the hazard unit, instruction memory and the IF/ID pipeline register.

---
 rtl/pc_fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC controller: owns the fetch PC, drives imem address,
// tags returned instructions and handles branch-unit redirects.
module pc_fetch_ctrl #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             PcSel,
    input  logic             JalSel,
    input  logic [31:0]      BrPC,
    input  logic [31:0]      Instr_In,
    output logic [PC_W-1:0]  Imem_Addr,
    output logic [31:0]      Instr_Out,
    output logic [PC_W-1:0]  Cur_PC,
    output logic             Instr_Valid,
    output logic             Flush_IfId,
    output logic             Flush_IdEx,
    output logic             Target_Err,
    output logic [CNT_W-1:0] Br_Count,
    output logic [CNT_W-1:0] Jmp_Count
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        SQUASH,
        HALT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PC_W-1:0]  r_fetch_pc;
    logic [PC_W-1:0]  r_resp_pc;
    logic [PC_W-1:0]  w_fetch_nxt;
    logic [PC_W-1:0]  w_resp_nxt;
    logic [PC_W-1:0]  w_fetch_inc;
    logic             r_err;
    logic             w_err_nxt;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_jmp_cnt;
    logic             w_redir;
    logic             w_bad_tgt;
    logic             w_inc_br;
    logic             w_inc_jmp;

    assign w_fetch_inc = r_fetch_pc + PC_W'(4);
    assign w_bad_tgt   = (BrPC[1:0] != 2'b00) || (BrPC[31:PC_W] != '0);
    assign w_redir     = PcSel && (r_state != HALT);

    always_comb begin
        w_state_nxt = r_state;
        w_fetch_nxt = r_fetch_pc;
        w_resp_nxt  = r_resp_pc;
        w_err_nxt   = r_err;
        w_inc_br    = 1'b0;
        w_inc_jmp   = 1'b0;
        if (w_redir) begin
            w_inc_jmp = JalSel;
            w_inc_br  = !JalSel;
            if (w_bad_tgt) begin
                w_err_nxt   = 1'b1;
                w_state_nxt = HALT;
            end else begin
                w_fetch_nxt = BrPC[PC_W-1:0];
                w_resp_nxt  = r_fetch_pc;
                w_state_nxt = SQUASH;
            end
        end else begin
            unique case (r_state)
                BOOT, SQUASH: begin
                    w_resp_nxt  = r_fetch_pc;
                    w_fetch_nxt = w_fetch_inc;
                    w_state_nxt = RUN;
                end
                RUN: begin
                    // a stall holds everything so the held instruction re-reads
                    if (!Stall) begin
                        w_resp_nxt  = r_fetch_pc;
                        w_fetch_nxt = w_fetch_inc;
                    end
                end
                HALT: begin
                    w_state_nxt = HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= BOOT;
            r_fetch_pc <= '0;
            r_resp_pc  <= '0;
            r_err      <= 1'b0;
            r_br_cnt   <= '0;
            r_jmp_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_nxt;
            r_resp_pc  <= w_resp_nxt;
            r_err      <= w_err_nxt;
            if (w_inc_br && (r_br_cnt != '1))
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            if (w_inc_jmp && (r_jmp_cnt != '1))
                r_jmp_cnt <= r_jmp_cnt + CNT_W'(1);
        end
    end

    assign Imem_Addr   = ((r_state == RUN) && Stall && !PcSel)
                         ? r_resp_pc : r_fetch_pc;
    assign Instr_Out   = Instr_In;
    assign Cur_PC      = r_resp_pc;
    assign Instr_Valid = reset && (r_state == RUN);
    assign Flush_IfId  = reset && w_redir;
    assign Flush_IdEx  = reset && w_redir;
    assign Target_Err  = r_err;
    assign Br_Count    = r_br_cnt;
    assign Jmp_Count   = r_jmp_cnt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed steps plus random
// traffic against a path-level model of the fetch stream.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        PcSel;
    logic        JalSel;
    logic [31:0] BrPC;
    logic [31:0] Instr_In;
    logic [8:0]  Imem_Addr;
    logic [31:0] Instr_Out;
    logic [8:0]  Cur_PC;
    logic        Instr_Valid;
    logic        Flush_IfId;
    logic        Flush_IdEx;
    logic        Target_Err;
    logic [15:0] Br_Count;
    logic [15:0] Jmp_Count;

    int n_chk  = 0;
    int n_pass = 0;

    // model: address stream seen by the decoder
    logic        m_valid;
    logic        m_halt;
    logic        m_err;
    logic [8:0]  m_next;
    logic [8:0]  m_cur;
    int unsigned m_br;
    int unsigned m_jmp;

    pc_fetch_ctrl #(.PC_W(9), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .Stall      (Stall),
        .PcSel      (PcSel),
        .JalSel     (JalSel),
        .BrPC       (BrPC),
        .Instr_In   (Instr_In),
        .Imem_Addr  (Imem_Addr),
        .Instr_Out  (Instr_Out),
        .Cur_PC     (Cur_PC),
        .Instr_Valid(Instr_Valid),
        .Flush_IfId (Flush_IfId),
        .Flush_IdEx (Flush_IdEx),
        .Target_Err (Target_Err),
        .Br_Count   (Br_Count),
        .Jmp_Count  (Jmp_Count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [8:0] a);
        return {16'hC0DE, 7'd0, a};
    endfunction

    always @(posedge clk) Instr_In <= memf(Imem_Addr);

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic m_reset();
        m_valid = 0;
        m_halt  = 0;
        m_err   = 0;
        m_next  = 0;
        m_cur   = 0;
        m_br    = 0;
        m_jmp   = 0;
    endtask

    task automatic check_outs();
        logic       fl;
        logic       vl;
        logic [8:0] ea;
        fl = reset && PcSel && !m_halt;
        vl = reset && m_valid && !m_halt;
        chk("valid", 32'(Instr_Valid), 32'(vl));
        chk("flush_ifid", 32'(Flush_IfId), 32'(fl));
        chk("flush_idex", 32'(Flush_IdEx), 32'(fl));
        chk("target_err", 32'(Target_Err), 32'(m_err));
        chk("br_count", 32'(Br_Count), m_br);
        chk("jmp_count", 32'(Jmp_Count), m_jmp);
        if (reset && !m_halt) begin
            ea = (m_valid && Stall && !PcSel) ? m_cur : m_next;
            chk("cur_pc", 32'(Cur_PC), 32'(m_cur));
            chk("imem_addr", 32'(Imem_Addr), 32'(ea));
        end
        if (reset && m_halt)
            chk("halt_addr", 32'(Imem_Addr), 32'(m_next));
        if (vl)
            chk("instr_out", Instr_Out, memf(m_cur));
    endtask

    task automatic m_step();
        if (!reset) begin
            m_reset();
        end else if (m_halt) begin
            m_halt = 1;
        end else if (PcSel) begin
            if (JalSel) begin
                if (m_jmp < 65535) m_jmp++;
            end else begin
                if (m_br < 65535) m_br++;
            end
            if (BrPC % 4 != 0 || BrPC >= 512) begin
                m_err   = 1;
                m_halt  = 1;
                m_valid = 0;
            end else begin
                m_cur   = m_next;
                m_next  = BrPC[8:0];
                m_valid = 0;
            end
        end else if (m_valid && Stall) begin
            m_valid = 1;
        end else begin
            m_cur   = m_next;
            m_next  = 9'((int'(m_next) + 4) % 512);
            m_valid = 1;
        end
    endtask

    task automatic cyc(input logic rst, input logic st,
                       input logic ps, input logic jal,
                       input logic [31:0] br);
        reset  = rst;
        Stall  = st;
        PcSel  = ps;
        JalSel = jal;
        BrPC   = br;
        @(negedge clk);
        check_outs();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 32'h0);
    endtask

    task automatic run_until(input logic [8:0] pc);
        for (int i = 0; i < 600; i++) begin
            if (m_valid && m_cur == pc) break;
            idle();
        end
        chk("reach_pc", 32'(Cur_PC), 32'(pc));
    endtask

    initial begin
        m_reset();
        // reset, with a redirect request that must not count
        cyc(0, 0, 0, 0, 32'h0);
        cyc(0, 1, 1, 0, 32'h40);
        cyc(0, 0, 1, 1, 32'h80);
        chk("rst_br", 32'(Br_Count), 32'h0);
        // release: BOOT then sequential fetch
        idle();
        chk("boot_valid", 32'(Instr_Valid), 32'h1);
        chk("boot_pc", 32'(Cur_PC), 32'h0);
        run_until(9'h010);
        // branch redirect
        cyc(1, 0, 1, 0, 32'h40);
        chk("sq_valid", 32'(Instr_Valid), 32'h0);
        idle();
        chk("br_pc", 32'(Cur_PC), 32'h40);
        chk("br_cnt1", 32'(Br_Count), 32'h1);
        // stall 3 cycles at 0x20
        cyc(1, 0, 1, 0, 32'h20);
        idle();
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 32'h0);
        chk("stall_pc", 32'(Cur_PC), 32'h20);
        idle();
        chk("stall_next", 32'(Cur_PC), 32'h24);
        // redirect wins over stall, jump class
        cyc(1, 1, 1, 1, 32'h80);
        idle();
        chk("jmp_pc", 32'(Cur_PC), 32'h80);
        chk("jmp_cnt1", 32'(Jmp_Count), 32'h1);
        chk("br_cnt2", 32'(Br_Count), 32'h2);
        // back-to-back redirects: second wins
        cyc(1, 0, 1, 0, 32'h100);
        cyc(1, 0, 1, 0, 32'h180);
        idle();
        chk("b2b_pc", 32'(Cur_PC), 32'h180);
        // wrap at top of address space
        cyc(1, 0, 1, 0, 32'h1F8);
        idle();
        idle();
        idle();
        chk("wrap_pc", 32'(Cur_PC), 32'h0);
        // illegal targets halt until reset
        cyc(1, 0, 1, 0, 32'h42);
        chk("err_misal", 32'(Target_Err), 32'h1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 32'h100);
        chk("halt_valid", 32'(Instr_Valid), 32'h0);
        cyc(0, 0, 0, 0, 32'h0);
        chk("err_clr", 32'(Target_Err), 32'h0);
        run_until(9'h000);
        cyc(1, 0, 1, 1, 32'h200);
        chk("err_range", 32'(Target_Err), 32'h1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 32'h40);
        cyc(0, 0, 0, 0, 32'h0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst;
            logic [31:0] r_br;
            r_rst = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 49) == 0) r_br = $urandom;
            else r_br = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
            cyc(r_rst, ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 7) == 0), 1'($urandom), r_br);
        end
        // branch counter saturation
        cyc(0, 0, 0, 0, 32'h0);
        idle();
        for (int i = 0; i < 65540; i++) cyc(1, 0, 1, 0, 32'h40);
        chk("br_sat", 32'(Br_Count), 32'hFFFF);
        chk("jmp_nosat", 32'(Jmp_Count), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
